// File: rtl/wb_banked_ram_if.sv
// Wishbone pipelined bus bundle for wb_banked_ram: one lane per slave port.
interface wb_banked_ram_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] wb_addr_i  [NUM_PORTS-1:0];
    logic [DATA_WIDTH-1:0] wb_data_i  [NUM_PORTS-1:0];
    logic [SEL_WIDTH-1:0]  wb_sel_i   [NUM_PORTS-1:0];
    logic                  wb_we_i    [NUM_PORTS-1:0];
    logic                  wb_stb_i   [NUM_PORTS-1:0];
    logic                  wb_ack_o   [NUM_PORTS-1:0];
    logic                  wb_stall_o [NUM_PORTS-1:0];
    logic [DATA_WIDTH-1:0] wb_data_o  [NUM_PORTS-1:0];

    modport slave (
        input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_stb_i,
        output wb_ack_o, wb_stall_o, wb_data_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_stb_i,
        input  wb_ack_o, wb_stall_o, wb_data_o
    );
endinterface

// File: rtl/wb_banked_ram.sv
// N-port pipelined Wishbone RAM over M single-port banks, round-robin arbitrated per bank.
// Optional stall counters with perf_clr_i/perf_stall_o when WB_BANKED_RAM_PERF_EN is defined.
module wb_banked_ram #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INTERLEAVE = 0
) (
    input  logic           clk,
    input  logic           rst,
    wb_banked_ram_if.slave wb
`ifdef WB_BANKED_RAM_PERF_EN
    ,
    input  logic           perf_clr_i,
    output logic [15:0]    perf_stall_o [NUM_PORTS-1:0]
`endif
);
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned PTR_BITS  = $clog2(NUM_PORTS);
    localparam int unsigned ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned DEPTH     = 2 ** ROW_BITS;
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    logic [BANK_BITS-1:0]  port_bank  [NUM_PORTS-1:0];
    logic [ROW_BITS-1:0]   port_row   [NUM_PORTS-1:0];
    logic [PTR_BITS-1:0]   rr_ptr_q   [NUM_BANKS-1:0];
    logic [PTR_BITS-1:0]   rr_ptr_d   [NUM_BANKS-1:0];
    logic                  bank_busy  [NUM_BANKS-1:0];
    logic [PTR_BITS-1:0]   bank_win   [NUM_BANKS-1:0];
    logic [SEL_WIDTH-1:0]  bank_we    [NUM_BANKS-1:0];
    logic [ROW_BITS-1:0]   bank_row   [NUM_BANKS-1:0];
    logic [DATA_WIDTH-1:0] bank_din   [NUM_BANKS-1:0];
    logic [DATA_WIDTH-1:0] bank_rd    [NUM_BANKS-1:0];
    logic [BANK_BITS-1:0]  sel_bank_q [NUM_PORTS-1:0];
    logic [NUM_PORTS-1:0]  grant_c;
    logic [NUM_PORTS-1:0]  stall_c;
    logic [NUM_PORTS-1:0]  ack_q;
    logic [PTR_BITS-1:0]   cand;

    // Split each port address into bank index and row within the bank
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (INTERLEAVE != 0) begin
                port_bank[p] = wb.wb_addr_i[p][BANK_BITS-1:0];
                port_row[p]  = wb.wb_addr_i[p][ADDR_WIDTH-1:BANK_BITS];
            end else begin
                port_bank[p] = wb.wb_addr_i[p][ADDR_WIDTH-1 -: BANK_BITS];
                port_row[p]  = wb.wb_addr_i[p][ROW_BITS-1:0];
            end
        end
    end

    // Per-bank round robin: first requester at or after rr_ptr wins; nothing is granted in reset
    always_comb begin
        grant_c = '0;
        cand    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_busy[b] = 1'b0;
            bank_win[b]  = '0;
            rr_ptr_d[b]  = rr_ptr_q[b];
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = rr_ptr_q[b] + PTR_BITS'(k);
                if (!bank_busy[b] && !rst && wb.wb_stb_i[cand] &&
                    (port_bank[cand] == BANK_BITS'(b))) begin
                    bank_busy[b] = 1'b1;
                    bank_win[b]  = cand;
                    grant_c[cand] = 1'b1;
                    rr_ptr_d[b]  = cand + PTR_BITS'(1);
                end
            end
        end
    end

    // Route the winning port's request onto its bank
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_row[b] = port_row[bank_win[b]];
            bank_din[b] = wb.wb_data_i[bank_win[b]];
            bank_we[b]  = (bank_busy[b] && wb.wb_we_i[bank_win[b]]) ? wb.wb_sel_i[bank_win[b]] : '0;
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // Behavioural sync single-port RAM: byte writes, 1-cycle read, contents survive reset
        always_ff @(posedge clk) begin
            if (bank_busy[gb]) begin
                for (int i = 0; i < SEL_WIDTH; i++) begin
                    if (bank_we[gb][i]) begin
                        mem[bank_row[gb]][i*8 +: 8] <= bank_din[gb][i*8 +: 8];
                    end
                end
                rd_q <= mem[bank_row[gb]];
            end
        end

        assign bank_rd[gb] = rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= '0;
            for (int p = 0; p < NUM_PORTS; p++) sel_bank_q[p] <= '0;
        end else begin
            ack_q <= grant_c;
            for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= rr_ptr_d[b];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant_c[p]) sel_bank_q[p] <= port_bank[p];
            end
        end
    end

    // Bus outputs: ack registered, stall combinational, read data muxed from the bank taken at accept
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            stall_c[p]       = wb.wb_stb_i[p] & ~grant_c[p];
            wb.wb_stall_o[p] = stall_c[p];
            wb.wb_ack_o[p]   = ack_q[p];
            wb.wb_data_o[p]  = bank_rd[sel_bank_q[p]];
        end
    end

`ifdef WB_BANKED_RAM_PERF_EN
    logic [15:0] perf_q [NUM_PORTS-1:0];

    // Saturating per-port stall counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) perf_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (perf_clr_i) begin
                    perf_q[p] <= '0;
                end else if (stall_c[p] && (perf_q[p] != 16'hFFFF)) begin
                    perf_q[p] <= perf_q[p] + 16'd1;
                end
            end
        end
    end

    assign perf_stall_o = perf_q;
`endif
endmodule
